mux4to1_32b: RTL and testbench

- 4-input, WIDTH-bit (default 32) word multiplexer for the 32-bit ALU datapath. It selects one of four operand/result words with a 2-bit select.
- Two outputs are provided:
  - `out`: a combinational result with zero latency. This is the path the ALU result mux uses.
  - `out_q`: a registered copy with a valid flag, for pipelined consumers.
- One clock domain; asynchronous active-low reset.

---
 rtl/mux4to1_32b.sv | 52 +++++
 tb/tb_mux4to1_32b.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux4to1_32b.sv
// 4:1 word mux with a zero-latency output and a registered, valid-qualified copy.
// The select decode runs in reverse letter order: 00 selects d and 11 selects a.
module mux4to1_32b #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  // An X/Z select matches no item, so the default drives X in simulation.
  always_comb begin
    w_sel = 'x;
    case (select)
      2'b00:   w_sel = d;
      2'b01:   w_sel = c;
      2'b10:   w_sel = b;
      2'b11:   w_sel = a;
      default: w_sel = 'x;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= RESET_VALUE;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_q <= w_sel;
      end
    end
  end

  assign out       = w_sel;
  assign out_q     = r_q;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux4to1_32b.sv
// Directed bench for mux4to1_32b: combinational decode, registered path,
// hold behaviour and asynchronous mid-operation reset.
module tb_mux4to1_32b;

  logic        clk;
  logic        rst_n;
  logic [31:0] out;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic [31:0] d;
  logic [1:0]  select;
  logic        in_valid;
  logic [31:0] out_q;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  mux4to1_32b #(
    .WIDTH(32),
    .RESET_VALUE(32'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .out      (out),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .select   (select),
    .in_valid (in_valid),
    .out_q    (out_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] vc, input logic [31:0] vd,
                       input logic [1:0] s);
    a = va;
    b = vb;
    c = vc;
    d = vd;
    select = s;
  endtask

  logic [31:0] ta[4];
  logic [31:0] tb[4];
  logic [31:0] tc[4];
  logic [31:0] td[4];
  logic [31:0] texp[4];

  initial begin
    ta[0] = 32'hFFFFFFFF; tb[0] = 32'h12345678;
    tc[0] = 32'h00000001; td[0] = 32'hFFFFFFFF;
    texp[0] = 32'hFFFFFFFF;
    ta[1] = 32'h00000001; tb[1] = 32'hFFFFFFFF;
    tc[1] = 32'h10000001; td[1] = 32'h10000000;
    texp[1] = 32'h10000001;
    ta[2] = 32'h10000001; tb[2] = 32'h10000000;
    tc[2] = 32'hFFFFFFFF; td[2] = 32'h12345678;
    texp[2] = 32'h10000000;
    ta[3] = 32'h00000001; tb[3] = 32'hFFFFFFFF;
    tc[3] = 32'h10000001; td[3] = 32'h10000000;
    texp[3] = 32'h00000001;

    rst_n = 1'b1;
    in_valid = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 2'b00);

    // Asynchronous reset between edges, no clock edge required.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_q", out_q, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);

    // Combinational decode, exercised while reset is still held.
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], tc[i], td[i], 2'(i));
      #1;
      chk($sformatf("comb_sel%0d", i), out, texp[i]);
    end

    // With select=11, only a may propagate.
    drive(32'h00000001, 32'hFFFFFFFF, 32'h10000001, 32'h10000000, 2'b11);
    b = 32'hA5A5A5A5; #1 chk("iso_b", out, 32'h00000001);
    c = 32'h5A5A5A5A; #1 chk("iso_c", out, 32'h00000001);
    d = 32'hDEADBEEF; #1 chk("iso_d", out, 32'h00000001);
    a = 32'hCAFEF00D; #1 chk("iso_a", out, 32'hCAFEF00D);
    select = 2'b00;   #1 chk("iso_sel00", out, 32'hDEADBEEF);
    chk("rst_hold_q", out_q, 32'h0);

    // Release reset away from the active edge.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rel_valid", {31'b0, out_valid}, 32'h0);

    // Four back-to-back captures, each visible one cycle later.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(ta[i], tb[i], tc[i], td[i], 2'(i));
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("reg_q%0d", i), out_q, texp[i]);
      chk($sformatf("reg_v%0d", i), {31'b0, out_valid}, 32'h1);
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("after_v", {31'b0, out_valid}, 32'h0);
    chk("after_q", out_q, 32'h00000001);

    // Input changes without in_valid must not disturb out_q.
    @(negedge clk);
    drive(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 2'b01);
    @(posedge clk); #1;
    chk("hold_q0", out_q, 32'h00000001);
    chk("hold_v0", {31'b0, out_valid}, 32'h0);
    chk("hold_out", out, 32'h33333333);
    @(negedge clk);
    select = 2'b10;
    @(posedge clk); #1;
    chk("hold_q1", out_q, 32'h00000001);
    chk("hold_v1", {31'b0, out_valid}, 32'h0);

    // Capture one word, then reset between edges with in_valid high.
    @(negedge clk);
    select = 2'b10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_q", out_q, 32'h22222222);
    chk("pre_rst_v", {31'b0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", out_q, 32'h0);
    chk("mid_rst_v", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_out", out, 32'h22222222);
    @(posedge clk); #1;
    chk("in_rst_q", out_q, 32'h0);
    chk("in_rst_v", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_q", out_q, 32'h0);
    chk("rel_v", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("rel_v2", {31'b0, out_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
